// File: rtl/pulse_gen_pkg.sv
// Shared types and defaults for the astable pulse generator.
package pulse_gen_pkg;

  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

endpackage

// File: rtl/astable_pulse_gen_phase_counter.sv
// Phase down-counter: loads a phase length, counts down, and flags the
// last cycle of the phase with a registered terminal-count bit.
module phase_counter
  import pulse_gen_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             ld_i,
  input  logic [CNT_W-1:0] ld_val_i,
  output logic             tc_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;

  // Next count: clear wins over load, load wins over decrement; stop at zero.
  // tc is derived from the next count so it is high while the count sits at 1.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (ld_i) begin
      cnt_d = ld_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
    tc_d = (cnt_d == ONE);
  end

  // Counter and terminal-count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/astable_pulse_gen.sv
// Astable square-wave source: programmable high/low phase lengths in clk
// cycles, registered edge strobes, an active-low per-period counter enable,
// and a free-running rising-edge count.
module astable_pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int unsigned      CNT_W    = CNT_W_DEF,
  parameter logic [CNT_W-1:0] HIGH_DEF = CNT_W'(4),
  parameter logic [CNT_W-1:0] LOW_DEF  = CNT_W'(4)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             load,
  input  logic [CNT_W-1:0] high_cycles,
  input  logic [CNT_W-1:0] low_cycles,
  output logic             wave,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             cnt_inhibit,
  output logic [7:0]       period_cnt,
  output logic             busy
);

  // A zero length would never reach terminal count, so it is treated as 1.
  function automatic logic [CNT_W-1:0] clamp1(input logic [CNT_W-1:0] len);
    return (len == '0) ? CNT_W'(1) : len;
  endfunction

  localparam logic [CNT_W-1:0] HIGH_RST = clamp1(HIGH_DEF);
  localparam logic [CNT_W-1:0] LOW_RST  = clamp1(LOW_DEF);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] high_len_q, high_len_d;
  logic [CNT_W-1:0] low_len_q, low_len_d;
  logic             wave_q, wave_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             inh_q;
  logic [7:0]       period_q, period_d;
  logic             busy_q;

  logic             cnt_clr;
  logic             cnt_ld;
  logic [CNT_W-1:0] cnt_ld_val;
  logic             tc;

  phase_counter #(
    .CNT_W (CNT_W)
  ) u_phase_counter (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (cnt_clr),
    .ld_i     (cnt_ld),
    .ld_val_i (cnt_ld_val),
    .tc_o     (tc)
  );

  // FSM next state, phase-counter control and next output values.
  // Phase loads use the current shadow lengths, so a load on the same edge
  // as a phase start only affects later phases.
  always_comb begin
    state_d    = state_q;
    wave_d     = wave_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    cnt_clr    = 1'b0;
    cnt_ld     = 1'b0;
    cnt_ld_val = '0;
    if (!run) begin
      state_d = IDLE;
      cnt_clr = 1'b1;
      wave_d  = 1'b0;
      fall_d  = wave_q;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d    = HIGH;
          wave_d     = 1'b1;
          rise_d     = 1'b1;
          cnt_ld     = 1'b1;
          cnt_ld_val = high_len_q;
        end
        HIGH: begin
          if (tc) begin
            state_d    = LOW;
            wave_d     = 1'b0;
            fall_d     = 1'b1;
            cnt_ld     = 1'b1;
            cnt_ld_val = low_len_q;
          end
        end
        LOW: begin
          if (tc) begin
            state_d    = HIGH;
            wave_d     = 1'b1;
            rise_d     = 1'b1;
            cnt_ld     = 1'b1;
            cnt_ld_val = high_len_q;
          end
        end
        default: begin
          state_d = IDLE;
          wave_d  = 1'b0;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  // Shadow length capture with zero clamp, and rising-edge count.
  always_comb begin
    high_len_d = high_len_q;
    low_len_d  = low_len_q;
    if (load) begin
      high_len_d = clamp1(high_cycles);
      low_len_d  = clamp1(low_cycles);
    end
    period_d = period_q + {7'd0, rise_d};
  end

  // State, shadow lengths and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      high_len_q <= HIGH_RST;
      low_len_q  <= LOW_RST;
      wave_q     <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      inh_q      <= 1'b1;
      period_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      high_len_q <= high_len_d;
      low_len_q  <= low_len_d;
      wave_q     <= wave_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      inh_q      <= ~rise_d;
      period_q   <= period_d;
      busy_q     <= (state_d != IDLE);
    end
  end

  assign wave        = wave_q;
  assign rise_pulse  = rise_q;
  assign fall_pulse  = fall_q;
  assign cnt_inhibit = inh_q;
  assign period_cnt  = period_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_astable_pulse_gen.sv
// Bench for astable_pulse_gen: phase-remaining model checked every cycle,
// plus directed scenarios with literal expectations and a decade counter
// driven from cnt_inhibit.
module tb_astable_pulse_gen;

  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             reset;
  logic             run;
  logic             load;
  logic [CNT_W-1:0] high_cycles;
  logic [CNT_W-1:0] low_cycles;
  logic             wave;
  logic             rise_pulse;
  logic             fall_pulse;
  logic             cnt_inhibit;
  logic [7:0]       period_cnt;
  logic             busy;

  int tests = 0;
  int fails = 0;

  astable_pulse_gen #(
    .CNT_W    (CNT_W),
    .HIGH_DEF (16'd4),
    .LOW_DEF  (16'd4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .load        (load),
    .high_cycles (high_cycles),
    .low_cycles  (low_cycles),
    .wave        (wave),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .cnt_inhibit (cnt_inhibit),
    .period_cnt  (period_cnt),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decade counter downstream: one-hot Q0..Q9, steps when cnt_inhibit is low.
  logic [9:0] dec_q;
  always @(posedge clk or posedge reset) begin
    if (reset) dec_q <= 10'd1;
    else if (!cnt_inhibit) dec_q <= {dec_q[8:0], dec_q[9]};
  end

  // Behavioural model: tracks whether oscillating, current level, and how
  // many cycles of the current phase remain.
  int m_active, m_lvl, m_rem, m_hl, m_ll, m_pc, m_rise, m_fall;

  always @(posedge clk) begin
    if (reset) begin
      m_active = 0; m_lvl = 0; m_rem = 0; m_hl = 4; m_ll = 4;
      m_pc = 0; m_rise = 0; m_fall = 0;
    end else begin
      m_rise = 0;
      m_fall = 0;
      if (!run) begin
        if (m_lvl == 1) m_fall = 1;
        m_lvl = 0;
        m_active = 0;
        m_rem = 0;
      end else if (m_active == 0) begin
        m_active = 1; m_lvl = 1; m_rem = m_hl; m_rise = 1;
      end else begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          if (m_lvl == 1) begin
            m_lvl = 0; m_rem = m_ll; m_fall = 1;
          end else begin
            m_lvl = 1; m_rem = m_hl; m_rise = 1;
          end
        end
      end
      if (m_rise == 1) m_pc = (m_pc + 1) % 256;
      if (load) begin
        m_hl = (high_cycles == '0) ? 1 : int'(high_cycles);
        m_ll = (low_cycles == '0) ? 1 : int'(low_cycles);
      end
    end
    #1;
    check("m_wave",   32'(wave),        32'(m_lvl));
    check("m_rise",   32'(rise_pulse),  32'(m_rise));
    check("m_fall",   32'(fall_pulse),  32'(m_fall));
    check("m_inhib",  32'(cnt_inhibit), 32'(m_rise == 0));
    check("m_period", 32'(period_cnt),  32'(m_pc));
    check("m_busy",   32'(busy),        32'(m_active));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int t2 [12] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1};

  initial begin
    reset = 1'b1; run = 1'b0; load = 1'b0;
    high_cycles = '0; low_cycles = '0;
    tick(3);
    check("rst_wave",  32'(wave),        32'd0);
    check("rst_inhib", 32'(cnt_inhibit), 32'd1);
    check("rst_pcnt",  32'(period_cnt),  32'd0);
    check("rst_busy",  32'(busy),        32'd0);
    reset = 1'b0;
    tick(2);

    // 1: defaults 4/4
    run = 1'b1;
    tick(1);                                     // after E1
    check("t1_rise",  32'(rise_pulse),  32'd1);
    check("t1_inhib", 32'(cnt_inhibit), 32'd0);
    check("t1_pcnt",  32'(period_cnt),  32'd1);
    check("t1_busy",  32'(busy),        32'd1);
    tick(3);                                     // after E4
    check("t1_wave_e4", 32'(wave), 32'd1);
    tick(1);                                     // after E5
    check("t1_wave_e5", 32'(wave),       32'd0);
    check("t1_fall_e5", 32'(fall_pulse), 32'd1);
    tick(19);                                    // after E24
    check("t1_pcnt24", 32'(period_cnt), 32'd3);
    check("t1_wave24", 32'(wave),       32'd0);

    // 2: load 2/5 during the last HIGH cycle (sampled on the HIGH->LOW edge)
    tick(4);                                     // after E28
    load = 1'b1; high_cycles = 16'd2; low_cycles = 16'd5;
    tick(1);                                     // after E29
    load = 1'b0;
    check("t2_wave0", 32'(wave), 32'(t2[0]));
    for (int i = 1; i < 12; i++) begin
      tick(1);
      check($sformatf("t2_wave%0d", i), 32'(wave), 32'(t2[i]));
    end                                          // after E40

    // 3: zero lengths clamp to 1/1
    load = 1'b1; high_cycles = '0; low_cycles = '0;
    tick(1);                                     // after E41
    load = 1'b0;
    check("t3_wave41", 32'(wave), 32'd1);
    for (int e = 42; e < 50; e++) begin
      tick(1);
      check($sformatf("t3_wave%0d", e), 32'(wave),       32'(e % 2));
      check($sformatf("t3_rise%0d", e), 32'(rise_pulse), 32'(e % 2));
      check($sformatf("t3_fall%0d", e), 32'(fall_pulse), 32'((e + 1) % 2));
    end                                          // after E49
    check("t3_pcnt", 32'(period_cnt), 32'd10);

    // 4: run=0 in the 2nd HIGH cycle
    load = 1'b1; high_cycles = 16'd3; low_cycles = 16'd3;
    tick(1);                                     // after E50: LOW of old length 1
    load = 1'b0;
    check("t4_wave50", 32'(wave), 32'd0);
    tick(1);                                     // after E51
    check("t4_rise51", 32'(rise_pulse), 32'd1);
    tick(1);                                     // after E52
    run = 1'b0;
    tick(1);                                     // after E53
    check("t4_wave53", 32'(wave),       32'd0);
    check("t4_fall53", 32'(fall_pulse), 32'd1);
    check("t4_busy53", 32'(busy),       32'd0);
    tick(1);                                     // after E54
    check("t4_fall54", 32'(fall_pulse), 32'd0);
    run = 1'b1;
    tick(1);                                     // after E55
    check("t4_rise55", 32'(rise_pulse), 32'd1);
    check("t4_pcnt55", 32'(period_cnt), 32'd12);
    tick(2);                                     // after E57
    check("t4_wave57", 32'(wave), 32'd1);
    tick(1);                                     // after E58
    check("t4_wave58", 32'(wave),       32'd0);
    check("t4_fall58", 32'(fall_pulse), 32'd1);

    // 5: asynchronous reset mid-LOW; load during reset is ignored
    tick(1);                                     // after E59
    #2;
    reset = 1'b1; run = 1'b0;
    load = 1'b1; high_cycles = 16'd7; low_cycles = 16'd7;
    #1;
    check("t5_wave",  32'(wave),        32'd0);
    check("t5_rise",  32'(rise_pulse),  32'd0);
    check("t5_fall",  32'(fall_pulse),  32'd0);
    check("t5_inhib", 32'(cnt_inhibit), 32'd1);
    check("t5_pcnt",  32'(period_cnt),  32'd0);
    check("t5_busy",  32'(busy),        32'd0);
    tick(2);
    load = 1'b0; reset = 1'b0;
    tick(2);

    // 6: ten periods step the decade counter once each, back to Q0
    run = 1'b1;
    tick(2);                                     // after F2
    check("t6_dec_q1", 32'(dec_q), 32'd2);
    tick(2);                                     // after F4
    check("t6_wave_f4", 32'(wave), 32'd1);
    tick(1);                                     // after F5: defaults 4/4 restored
    check("t6_wave_f5", 32'(wave), 32'd0);
    tick(29);                                    // after F34
    check("t6_dec_q5", 32'(dec_q), 32'd32);
    tick(40);                                    // after F74
    check("t6_dec_q0", 32'(dec_q),      32'd1);
    check("t6_pcnt",   32'(period_cnt), 32'd10);
    run = 1'b0;
    tick(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule
